// File: rtl/out_act_wb_buffer.sv
// out_act_wb_buffer: output-activation register file with MAC writeback, bypassed accumulator read, clear and drain.
module out_act_wb_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ACT_NO     = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  comp_en_wb,
  input  logic [ADDR_WIDTH-1:0] out_act_addr_wb,
  input  logic [DATA_WIDTH-1:0] mac_result_wb,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] out_act_value_mac,
  input  logic                  clear_start,
  input  logic                  drain_start,
  output logic                  busy,
  output logic                  drain_valid,
  input  logic                  drain_ready,
  output logic [ADDR_WIDTH-1:0] drain_addr,
  output logic [DATA_WIDTH-1:0] drain_value,
  output logic                  drain_done,
  output logic                  wr_drop_err
);
  localparam logic [ADDR_WIDTH:0]   ACT_N = ACT_NO[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(ACT_NO - 1);
  typedef enum logic [1:0] {IDLE, CLEAR, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, drain_addr_q, drain_addr_d, rd_addr_q, rd_addr_d, drain_next;
  logic [DATA_WIDTH-1:0] drain_value_q, drain_value_d, rd_data_q, rd_data_d, rd_mem;
  logic drain_valid_q, drain_valid_d, drain_done_q, drain_done_d, busy_q, busy_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [ACT_NO];
  logic wr_ok, mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  always_comb begin
    wr_ok = (state_q == IDLE) && comp_en_wb && ({1'b0, out_act_addr_wb} < ACT_N);
    mem_we = !rst && (wr_ok || state_q == CLEAR);
    mem_waddr = (state_q == CLEAR) ? idx_q : out_act_addr_wb;
    mem_wdata = (state_q == CLEAR) ? '0 : mac_result_wb;
    rd_mem = ({1'b0, rd_addr} < ACT_N) ? mem_q[rd_addr] : '0;
    rd_data_d = !rd_en ? rd_data_q : (wr_ok && out_act_addr_wb == rd_addr) ? mac_result_wb : rd_mem;
    rd_addr_d = rd_en ? rd_addr : rd_addr_q;
    out_act_value_mac = (wr_ok && out_act_addr_wb == rd_addr_q) ? mac_result_wb : rd_data_q;
    drain_next = drain_addr_q + 1'b1;
    err_d = err_q | (busy_q & comp_en_wb);
    state_d = state_q;
    idx_d = idx_q;
    busy_d = busy_q;
    drain_addr_d = drain_addr_q;
    drain_value_d = drain_value_q;
    drain_valid_d = drain_valid_q;
    drain_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          idx_d = '0;
          busy_d = 1'b1;
        end else if (drain_start) begin
          state_d = DRAIN;
          busy_d = 1'b1;
          drain_addr_d = '0;
          drain_value_d = (wr_ok && out_act_addr_wb == '0) ? mac_result_wb : mem_q[0];
          drain_valid_d = 1'b1;
        end
      end
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          busy_d = 1'b0;
        end
      end
      DRAIN: begin
        if (drain_valid_q && drain_ready) begin
          if (drain_addr_q == LAST) begin
            state_d = IDLE;
            busy_d = 1'b0;
            drain_valid_d = 1'b0;
            drain_done_d = 1'b1;
          end else begin
            drain_addr_d = drain_next;
            drain_value_d = mem_q[drain_next];
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d = 1'b0;
        drain_valid_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      busy_q <= 1'b0;
      drain_addr_q <= '0;
      drain_value_q <= '0;
      drain_valid_q <= 1'b0;
      drain_done_q <= 1'b0;
      err_q <= 1'b0;
      rd_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      busy_q <= busy_d;
      drain_addr_q <= drain_addr_d;
      drain_value_q <= drain_value_d;
      drain_valid_q <= drain_valid_d;
      drain_done_q <= drain_done_d;
      err_q <= err_d;
      rd_data_q <= rd_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end
  // Array is deliberately not reset; software zeroes it with clear_start.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end
  assign busy = busy_q;
  assign drain_valid = drain_valid_q;
  assign drain_addr = drain_addr_q;
  assign drain_value = drain_value_q;
  assign drain_done = drain_done_q;
  assign wr_drop_err = err_q;
endmodule

// File: tb/tb_out_act_wb_buffer.sv
// tb_out_act_wb_buffer: randomized self-checking bench against an array model of the activation buffer.
module tb_out_act_wb_buffer;
  localparam int DW = 16, N = 16, AW = 4;
  logic clk = 0, rst = 1, comp_en_wb = 0, rd_en = 0, clear_start = 0, drain_start = 0, drain_ready = 0;
  logic [AW-1:0] out_act_addr_wb = 0, rd_addr = 0;
  logic [DW-1:0] mac_result_wb = 0;
  logic [DW-1:0] out_act_value_mac, drain_value;
  logic [AW-1:0] drain_addr;
  logic busy, drain_valid, drain_done, wr_drop_err;
  int tests = 0, fails = 0;
  logic [DW-1:0] model [N];

  out_act_wb_buffer #(.DATA_WIDTH(DW), .ACT_NO(N), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .comp_en_wb(comp_en_wb), .out_act_addr_wb(out_act_addr_wb),
    .mac_result_wb(mac_result_wb), .rd_en(rd_en), .rd_addr(rd_addr),
    .out_act_value_mac(out_act_value_mac), .clear_start(clear_start), .drain_start(drain_start),
    .busy(busy), .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_addr(drain_addr),
    .drain_value(drain_value), .drain_done(drain_done), .wr_drop_err(wr_drop_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    comp_en_wb = 1; out_act_addr_wb = a; mac_result_wb = d;
    tick();
    comp_en_wb = 0;
    model[a] = d;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_en = 1; rd_addr = a;
    tick();
    rd_en = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    tests++;
    if (busy !== 0 || drain_valid !== 0 || drain_done !== 0 || wr_drop_err !== 0) begin
      fails++; $display("FAIL reset_flags: busy=%b valid=%b done=%b err=%b, required all 0", busy, drain_valid, drain_done, wr_drop_err);
    end
    tests++;
    if (drain_addr !== 0 || drain_value !== 0 || out_act_value_mac !== 0) begin
      fails++; $display("FAIL reset_data: addr=%0d value=%h mac=%h, required 0", drain_addr, drain_value, out_act_value_mac);
    end
  endtask

  task automatic wait_clear(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin cnt++; tick(); end
    for (int i = 0; i < N; i++) model[i] = 0;
  endtask

  task automatic test_clear();
    int cnt;
    clear_start = 1; drain_start = 1;
    tick();
    clear_start = 0; drain_start = 0;
    wait_clear(cnt);
    tests++;
    if (cnt !== N) begin fails++; $display("FAIL clear_busy_cycles: got %0d, required %0d", cnt, N); end
  endtask

  task automatic do_drain(input int mode);
    int beat = 0, cyc = 0;
    logic held = 0, r;
    logic [AW-1:0] ha = 0;
    logic [DW-1:0] hv = 0;
    drain_start = 1;
    tick();
    drain_start = 0;
    while (beat < N && cyc < 200) begin
      if (held) begin
        tests++;
        if (drain_addr !== ha || drain_value !== hv) begin
          fails++; $display("FAIL drain_hold: addr=%0d value=%h, required addr=%0d value=%h", drain_addr, drain_value, ha, hv);
        end
      end
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      drain_ready = r;
      if (!drain_valid) begin
        tests++; fails++;
        $display("FAIL drain_valid: low at beat %0d, required 1", beat);
        cyc = 200;
      end else if (r) begin
        tests++;
        if (drain_addr !== AW'(beat) || drain_value !== model[beat]) begin
          fails++; $display("FAIL drain_beat: addr=%0d value=%h, required addr=%0d value=%h", drain_addr, drain_value, beat, model[beat]);
        end
        beat++; held = 0;
      end else begin
        held = 1; ha = drain_addr; hv = drain_value;
      end
      tick();
      cyc++;
    end
    drain_ready = 0;
    tests++;
    if (beat !== N) begin fails++; $display("FAIL drain_count: got %0d beats, required %0d", beat, N); end
    tests++;
    if (drain_done !== 1 || busy !== 0 || drain_valid !== 0) begin
      fails++; $display("FAIL drain_end: done=%b busy=%b valid=%b, required 1 0 0", drain_done, busy, drain_valid);
    end
    tick();
    tests++;
    if (drain_done !== 0) begin fails++; $display("FAIL drain_done_pulse: got %b, required 0", drain_done); end
  endtask

  task automatic test_write_read();
    wr(3, 16'h0010);
    wr(5, 16'h0020);
    rd(3);
    tests++;
    if (out_act_value_mac !== 16'h0010) begin fails++; $display("FAIL read_addr3: got %h, required 0010", out_act_value_mac); end
    rd(5);
    tests++;
    if (out_act_value_mac !== 16'h0020) begin fails++; $display("FAIL read_addr5: got %h, required 0020", out_act_value_mac); end
  endtask

  task automatic test_bypass();
    rd(7);
    comp_en_wb = 1; out_act_addr_wb = 7; mac_result_wb = 16'h0055;
    #1;
    tests++;
    if (out_act_value_mac !== 16'h0055) begin fails++; $display("FAIL bypass2: got %h, required 0055", out_act_value_mac); end
    tick();
    comp_en_wb = 0; model[7] = 16'h0055;
    rd_en = 1; rd_addr = 7; comp_en_wb = 1; out_act_addr_wb = 7; mac_result_wb = 16'h0066;
    tick();
    rd_en = 0; comp_en_wb = 0; model[7] = 16'h0066;
    tests++;
    if (out_act_value_mac !== 16'h0066) begin fails++; $display("FAIL bypass1: got %h, required 0066", out_act_value_mac); end
    wr(8, 16'hbeef);
    tick();
    tests++;
    if (out_act_value_mac !== 16'h0066) begin fails++; $display("FAIL read_hold: got %h, required 0066", out_act_value_mac); end
  endtask

  // Read result at t+1 must equal the newest value of the entry, including a write landing at t+1.
  task automatic test_random_rw();
    logic [AW-1:0] pa = 0, ra, wa;
    logic [DW-1:0] wd, exp;
    logic we;
    for (int i = 0; i < 60; i++) begin
      ra = AW'($urandom_range(0, N - 1));
      wa = AW'($urandom_range(0, N - 1));
      wd = DW'($urandom);
      we = 1'($urandom_range(0, 1));
      rd_en = 1; rd_addr = ra;
      comp_en_wb = we; out_act_addr_wb = wa; mac_result_wb = wd;
      #1;
      exp = (we && wa == pa) ? wd : model[pa];
      if (i > 0) begin
        tests++;
        if (out_act_value_mac !== exp) begin fails++; $display("FAIL random_read: addr=%0d got %h, required %h", pa, out_act_value_mac, exp); end
      end
      if (we) model[wa] = wd;
      pa = ra;
      tick();
    end
    rd_en = 0; comp_en_wb = 0;
  endtask

  task automatic test_drain_toggle();
    for (int i = 0; i < N; i++) wr(AW'(i), DW'($urandom));
    do_drain(1);
  endtask

  task automatic test_drop_err();
    int cnt;
    clear_start = 1;
    tick();
    clear_start = 0;
    comp_en_wb = 1; out_act_addr_wb = 2; mac_result_wb = 16'h1234;
    tick();
    comp_en_wb = 0;
    tests++;
    if (wr_drop_err !== 1) begin fails++; $display("FAIL drop_err_set: got %b, required 1", wr_drop_err); end
    wait_clear(cnt);
    tick();
    tests++;
    if (wr_drop_err !== 1) begin fails++; $display("FAIL drop_err_sticky: got %b, required 1", wr_drop_err); end
    rd(2);
    tests++;
    if (out_act_value_mac !== 0) begin fails++; $display("FAIL drop_entry2: got %h, required 0000", out_act_value_mac); end
  endtask

  task automatic test_reset_mid_drain();
    int cyc = 0;
    for (int i = 0; i < N; i++) wr(AW'(i), DW'($urandom));
    drain_start = 1;
    tick();
    drain_start = 0;
    drain_ready = 1;
    while (drain_addr !== 6 && cyc < 50) begin tick(); cyc++; end
    tests++;
    if (drain_addr !== 6) begin fails++; $display("FAIL mid_drain_reach: addr=%0d, required 6", drain_addr); end
    rst = 1; drain_ready = 0;
    tick();
    rst = 0;
    tests++;
    if (busy !== 0 || drain_valid !== 0 || drain_done !== 0 || wr_drop_err !== 0) begin
      fails++; $display("FAIL mid_drain_reset: busy=%b valid=%b done=%b err=%b, required all 0", busy, drain_valid, drain_done, wr_drop_err);
    end
    do_drain(2);
  endtask

  initial begin
    test_reset();
    test_clear();
    do_drain(0);
    test_write_read();
    test_bypass();
    test_random_rw();
    test_drain_toggle();
    test_drop_err();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
